// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the cartridge ROM/BSRAM port.
// Port A has priority; a starvation counter forces port B through.
module rom_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_word,
  input  logic [7:0]        a_d,
  output logic              a_ack,
  output logic [15:0]       a_q,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_word,
  input  logic [7:0]        b_d,
  output logic              b_ack,
  output logic [15:0]       b_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_d,
  input  logic [15:0]       mem_q,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_word,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            go;
  logic            pick_b;
  logic            last;
  logic            grant_b;
  logic            we_r;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic [15:0]     rd_q;

  assign last = (lat_cnt == LW'(MEM_LAT - 1));
  assign busy = (state != IDLE);
  assign rd_q = mem_word ? mem_q : {8'h00, mem_q[7:0]};

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    pick_b    = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          go        = 1'b1;
          pick_b    = b_req &&
                      (!a_req ||
                       starve_cnt == SW'(STARVE_MAX));
          state_nxt = ACCESS;
        end
      end
      ACCESS: if (last) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      grant_b    <= 1'b0;
      we_r       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      mem_addr   <= '0;
      mem_d      <= 8'h00;
      mem_word   <= 1'b0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (go) begin
        grant_b  <= pick_b;
        we_r     <= pick_b ? b_we : a_we;
        mem_addr <= pick_b ? b_addr : a_addr;
        mem_d    <= pick_b ? b_d : a_d;
        mem_word <= pick_b ? b_word : a_word;
        mem_ce_n <= 1'b0;
        mem_oe_n <= pick_b ? b_we : a_we;
        mem_we_n <= pick_b ? ~b_we : ~a_we;
        lat_cnt  <= '0;
        if (pick_b)
          starve_cnt <= '0;
        else if (b_req &&
                 starve_cnt != SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + SW'(1);
      end
      if (state == ACCESS) begin
        lat_cnt <= lat_cnt + LW'(1);
        if (last) begin
          mem_ce_n <= 1'b1;
          mem_oe_n <= 1'b1;
          mem_we_n <= 1'b1;
          if (grant_b) begin
            b_ack <= 1'b1;
            if (!we_r) b_q <= rd_q;
          end else begin
            a_ack <= 1'b1;
            if (!we_r) a_q <= rd_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: latency, priority,
// starvation relief, writes and mid-access reset.
module tb_rom_port_arbiter;

  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic        a_req, a_we, a_word;
  logic [23:0] a_addr;
  logic [7:0]  a_d;
  logic        a_ack;
  logic [15:0] a_q;
  logic        b_req, b_we, b_word;
  logic [23:0] b_addr;
  logic [7:0]  b_d;
  logic        b_ack;
  logic [15:0] b_q;
  logic [23:0] mem_addr;
  logic [7:0]  mem_d;
  logic [15:0] mem_q;
  logic        mem_ce_n, mem_oe_n, mem_we_n;
  logic        mem_word, busy;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int t0;
  int ce_low, oe_low, we_low;
  int a_acks, b_acks, a_at, b_at;
  int hold;
  bit seq [64];
  int nseq;

  rom_port_arbiter dut (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we),
    .a_word(a_word), .a_d(a_d), .a_ack(a_ack),
    .a_q(a_q),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we),
    .b_word(b_word), .b_d(b_d), .b_ack(b_ack),
    .b_q(b_q),
    .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_q(mem_q), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_word(mem_word), .busy(busy)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge MCLK);
    #1;
    cyc_n++;
  endtask

  task automatic clr();
    t0 = cyc_n;
    ce_low = 0; oe_low = 0; we_low = 0;
    a_acks = 0; b_acks = 0;
    a_at = 0; b_at = 0; nseq = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (!mem_ce_n) ce_low++;
      if (!mem_oe_n) oe_low++;
      if (!mem_we_n) we_low++;
      chk("two_acks", 32'(a_ack & b_ack), 32'd0);
      chk("oe_we_low", 32'(!mem_oe_n && !mem_we_n),
          32'd0);
      if (a_ack) begin
        a_acks++;
        if (a_at == 0) a_at = cyc_n - t0;
        if (nseq < 64) seq[nseq++] = 1'b0;
        if (hold == 0) a_req = 1'b0;
      end
      if (b_ack) begin
        b_acks++;
        if (b_at == 0) b_at = cyc_n - t0;
        if (nseq < 64) seq[nseq++] = 1'b1;
        if (hold == 0) b_req = 1'b0;
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    a_req = 0; a_we = 0; a_word = 0;
    a_addr = '0; a_d = '0;
    b_req = 0; b_we = 0; b_word = 0;
    b_addr = '0; b_d = '0;
    mem_q = 16'h0000;
    hold = 0;
    cyc(); cyc(); cyc();
    RESET_N = 1'b1;

    // 1: idle after reset
    clr();
    run(20);
    chk("idle_ce_low", ce_low, 0);
    chk("idle_acks", a_acks + b_acks, 0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_a_q", 32'(a_q), 32'd0);
    chk("idle_b_q", 32'(b_q), 32'd0);
    chk("idle_oe_we", 32'({mem_oe_n, mem_we_n}),
        32'd3);
    chk("idle_addr", 32'(mem_addr), 32'd0);

    // 2: A word read
    mem_q = 16'hBEEF;
    a_addr = 24'h008000; a_we = 0; a_word = 1;
    a_req = 1;
    clr();
    run(1);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h008000);
    chk("rd_word", 32'(mem_word), 32'd1);
    run(11);
    chk("rd_ce_low", ce_low, 4);
    chk("rd_oe_low", oe_low, 4);
    chk("rd_we_low", we_low, 0);
    chk("rd_ack_at", a_at, 5);
    chk("rd_ack_cnt", a_acks, 1);
    chk("rd_a_q", 32'(a_q), 32'hBEEF);
    chk("rd_busy_end", 32'(busy), 32'd0);

    // A byte read keeps only the low byte
    mem_q = 16'h1234;
    a_addr = 24'h00FFFE; a_word = 0;
    a_req = 1;
    clr();
    run(12);
    chk("byte_ack_cnt", a_acks, 1);
    chk("byte_a_q", 32'(a_q), 32'h0034);

    // 3: B byte write, data change after grant
    b_addr = 24'h700010; b_we = 1; b_word = 0;
    b_d = 8'h5A;
    b_req = 1;
    clr();
    run(1);
    b_d = 8'hFF;
    run(11);
    chk("wr_we_low", we_low, 4);
    chk("wr_oe_low", oe_low, 0);
    chk("wr_mem_d", 32'(mem_d), 32'h5A);
    chk("wr_addr", 32'(mem_addr), 32'h700010);
    chk("wr_ack_cnt", b_acks, 1);
    chk("wr_ack_at", b_at, 5);
    chk("wr_b_q", 32'(b_q), 32'd0);
    chk("wr_a_q", 32'(a_q), 32'h0034);
    b_we = 0;

    // 5: both raised together, starve_cnt = 0
    mem_q = 16'h0A0B;
    a_word = 1; b_word = 1;
    a_req = 1; b_req = 1;
    clr();
    run(20);
    chk("both_a_at", a_at, 5);
    chk("both_b_at", b_at, 11);
    chk("both_first", 32'(seq[0]), 32'd0);

    // 4: continuous traffic on both ports
    hold = 1;
    a_req = 1; b_req = 1;
    clr();
    run(108);
    a_req = 0; b_req = 0;
    hold = 0;
    run(10);
    chk("cont_n", nseq, 18);
    for (int k = 0; k < 18; k++)
      chk($sformatf("cont_seq%0d", k),
          32'(seq[k]), 32'((k % 9) == 8));
    chk("cont_a_acks", a_acks, 16);
    chk("cont_b_acks", b_acks, 2);

    // 6: reset in the middle of an A read
    mem_q = 16'h5555;
    a_word = 1;
    a_req = 1;
    clr();
    run(3);
    RESET_N = 1'b0;
    #1;
    chk("rst_ce", 32'(mem_ce_n), 32'd1);
    chk("rst_oe_we", 32'({mem_oe_n, mem_we_n}),
        32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_a_q", 32'(a_q), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    a_req = 0;
    #2;
    RESET_N = 1'b1;
    run(10);
    chk("rst_no_ack", a_acks, 0);
    mem_q = 16'hCAFE;
    a_req = 1;
    clr();
    run(12);
    chk("rst_re_at", a_at, 5);
    chk("rst_re_q", 32'(a_q), 32'hCAFE);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
